// File: rtl/minmax_pkg.sv
// Shared constants and helpers for the min/max tree.
// MINMAX_SIGNED_EN selects two's-complement lanes and signed pad identities.
package minmax_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  localparam int unsigned PAD_MAX_W = 64;

`ifdef MINMAX_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 32'd1 : r;
  endfunction

  // Identity for the selected reduction; callers truncate to their lane width.
  function automatic logic [PAD_MAX_W-1:0] pad_identity(input logic mode, input int unsigned w);
    logic [PAD_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < PAD_MAX_W; i++) begin
      if (i + 1 < w)
        v[i[5:0]] = (mode == MODE_MIN);
      else if (i + 1 == w)
        v[i[5:0]] = SIGNED_EN ? (mode == MODE_MAX) : (mode == MODE_MIN);
    end
    return v;
  endfunction

endpackage

// File: rtl/minmax_node.sv
// Combinational two-input min/max compare; ties keep input a (the lower index).
// MINMAX_SIGNED_EN switches the compare to two's-complement.
module minmax_node
  import minmax_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              mode,
  input  logic [DATA_W-1:0] a_data,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] b_data,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [DATA_W-1:0] y_data,
  output logic [IDX_W-1:0]  y_idx
);

  logic b_lt;
  logic b_gt;
  logic take_b;

  always_comb begin
`ifdef MINMAX_SIGNED_EN
    b_lt = $signed(b_data) < $signed(a_data);
    b_gt = $signed(b_data) > $signed(a_data);
`else
    b_lt = b_data < a_data;
    b_gt = b_data > a_data;
`endif
    take_b = (mode == MODE_MAX) ? b_gt : b_lt;
    y_data = take_b ? b_data : a_data;
    y_idx  = take_b ? b_idx : a_idx;
  end

endmodule

// File: rtl/minmax_tree_pipe.sv
// Pipelined NUM_IN-lane min/max selector with valid/ready handshake.
// MINMAX_SIGNED_EN builds a signed variant (see minmax_pkg / minmax_node).
module minmax_tree_pipe
  import minmax_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned LEVELS = clog2_min1(NUM_IN),
  localparam int unsigned IDX_W  = clog2_min1(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx
);

  localparam int unsigned PADN  = 32'd1 << LEVELS;
  localparam int unsigned NODES = PADN - 1;

  logic              adv;
  logic [DATA_W-1:0] lane_data [PADN];
  logic [IDX_W-1:0]  lane_idx  [PADN];
  // Node registers stored flat, level by level: level l starts at PADN - (PADN >> (l-1)).
  logic [DATA_W-1:0] nxt_data  [NODES];
  logic [IDX_W-1:0]  nxt_idx   [NODES];
  logic [DATA_W-1:0] node_data [NODES];
  logic [IDX_W-1:0]  node_idx  [NODES];
  logic [LEVELS-1:0] vld;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < PADN; k++) begin : g_lane
    assign lane_idx[k] = IDX_W'(k);
    if (k < NUM_IN) begin : g_real
      assign lane_data[k] = in_data[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign lane_data[k] = DATA_W'(pad_identity(in_mode, DATA_W));
    end
  end

  // Mode of the sample held in levels 1..LEVELS-1; the last level needs none.
  if (LEVELS > 1) begin : g_mode
    logic [LEVELS-2:0] md;
    always_ff @(posedge clk) begin
      if (rst)
        md <= '0;
      else if (adv)
        md <= (LEVELS-1)'({md, in_mode});
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT = PADN >> l;
    localparam int unsigned OFF = PADN - (PADN >> (l - 1));
    logic lvl_mode;

    if (l == 1) begin : g_m_in
      assign lvl_mode = in_mode;
    end else begin : g_m_reg
      assign lvl_mode = g_mode.md[l-2];
    end

    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic [DATA_W-1:0] a_data;
      logic [DATA_W-1:0] b_data;
      logic [IDX_W-1:0]  a_idx;
      logic [IDX_W-1:0]  b_idx;

      if (l == 1) begin : g_src_in
        assign a_data = lane_data[2*j];
        assign b_data = lane_data[2*j+1];
        assign a_idx  = lane_idx[2*j];
        assign b_idx  = lane_idx[2*j+1];
      end else begin : g_src_reg
        localparam int unsigned SRC = OFF - 2 * CNT + 2 * j;
        assign a_data = node_data[SRC];
        assign b_data = node_data[SRC+1];
        assign a_idx  = node_idx[SRC];
        assign b_idx  = node_idx[SRC+1];
      end

      minmax_node #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
      ) u_node (
        .mode  (lvl_mode),
        .a_data(a_data),
        .a_idx (a_idx),
        .b_data(b_data),
        .b_idx (b_idx),
        .y_data(nxt_data[OFF+j]),
        .y_idx (nxt_idx[OFF+j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      node_data <= '{default: '0};
      node_idx  <= '{default: '0};
    end else if (adv) begin
      vld       <= LEVELS'({vld, in_valid});
      node_data <= nxt_data;
      node_idx  <= nxt_idx;
    end
  end

  assign out_valid = vld[LEVELS-1];
  assign out_data  = node_data[NODES-1];
  assign out_idx   = node_idx[NODES-1];

endmodule

// File: doc/minmax_tree_pipe.md
Name: minmax_tree_pipe

Overview:
- Parametrised, pipelined N-input min/max selector. Successor to the fixed 3-input registered-min block.
- Reduces NUM_IN lanes through a registered binary compare tree, one register level per tree level.
- Reports the winning value and its lane index. Runtime mode selects min or max per sample.
- Valid/ready handshake with backpressure, for use inside streaming datapaths.

Parameters:
- DATA_W, 8, width of each lane and of out_data.
- NUM_IN, 4, number of input lanes; any value ≥ 1, not restricted to a power of two.
- LEVELS, derived as max(1, clog2(NUM_IN)), number of pipeline stages; not to be overridden.
- IDX_W, derived as max(1, clog2(NUM_IN)), width of out_idx; not to be overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_mode  in  1  0 = min, 1 = max; sampled with the data.
- in_data  in  NUM_IN*DATA_W  lanes packed; lane k is bits [k*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  selected min/max value.
- out_idx  out  IDX_W  lowest lane index holding that value.

Behaviour:
- Reset (rst=1 at a clk edge): every stage valid, out_valid, out_data and out_idx clear to 0. Stage data, index and mode registers clear to 0. Reset has priority over all other inputs.
- Global advance: adv = !(out_valid && !out_ready); in_ready = adv. The pipeline is a shift register gated by adv. Bubbles advance, so no holes are collapsed.
- Transfer: a sample is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Latency: LEVELS cycles from acceptance to out_valid with no stall (NUM_IN=4 → 2, NUM_IN=3 → 2, NUM_IN=1 → 1).
- Throughput: 1 sample/cycle while out_ready=1.
- Stall: when adv=0, all stage registers and outputs hold their value. Outputs stay stable while out_valid=1 and out_ready=0.
- Padding: the tree is built on 2^LEVELS lanes. Pad lanes carry the identity value:
  - min mode: all-ones (signed build: max positive).
  - max mode: zero (signed build: most-negative).
  - Pad indices are above NUM_IN-1, so a pad lane never wins a tie against a real lane.
- Compare node: for inputs (a, ia) and (b, ib) with ia < ib:
  - min mode selects b only if b < a.
  - max mode selects b only if b > a.
  - Ties keep a, so the lowest index wins.
  - Comparison is unsigned by default.
- Mode travels with the sample through every stage. Changing in_mode between accepted samples affects only later samples; back-to-back samples of opposite mode are legal.
- Index: each node forwards the winner's index, widened level by level to IDX_W.
- NUM_IN=1: single register stage; out_data = lane 0, out_idx = 0.
- Synchronous reset mid-stream discards all in-flight samples. in_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro MINMAX_SIGNED_EN.
- Defined: lanes and out_data are two's-complement; compares are signed; pad identities are signed extremes.
- Undefined: unsigned compares, unsigned pad identities.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Shared package minmax_pkg:
  - mode constants MODE_MIN=1'b0, MODE_MAX=1'b1;
  - function clog2_min1;
  - pad-identity function of (mode, DATA_W), honouring MINMAX_SIGNED_EN.
- One sub-module, minmax_node: combinational two-input compare that selects value and index, with mode input and tie rule. The top generates the register levels around instances of it.

Test Plan:
- DATA_W=8, NUM_IN=4, min, in_data lanes {0:0x40, 1:0x10, 2:0x80, 3:0x10} → 2 cycles later out_valid=1, out_data=0x10, out_idx=1 (tie resolves to lowest lane).
- Same bench, max mode, lanes {0x05, 0xFF, 0x7F, 0x00} → out_data=0xFF, out_idx=1. Alternate min/max on consecutive cycles with fixed lanes {3,9,1,7} → results 1/idx2, 9/idx1, 1/idx2… at one result per cycle.
- NUM_IN=3, min, lanes {0xFF, 0xFF, 0xFF} → out_data=0xFF, out_idx=0 (pad lane never wins).
- Backpressure: stream 6 samples, hold out_ready=0 for 3 cycles once the first result is valid → out_data/out_idx stable, in_ready=0 during the hold; afterwards all 6 results arrive in order with none lost or duplicated.
- Signed build (MINMAX_SIGNED_EN), min, lanes {0x01, 0x80, 0x7F, 0xFF} → out_data=0x80, out_idx=1. Unsigned build, same stimulus → out_data=0x01, out_idx=0.
- Assert rst for 1 cycle with 2 samples in flight → next cycle out_valid=0, out_data=0, out_idx=0, in_ready=1; no stale result appears later.
